// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program_counter feedback, instruction memory port and the
// one-entry instruction buffer handshake toward decode.
interface fetch_unit_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] pc_out;
    logic [WORD_W-1:0] pc_in;
    logic              pcWEN;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // The fetch unit itself.
    modport master (
        input  pc_out, ihit, imemload, redirect, redirect_pc, halt, instr_ready,
        output pc_in, pcWEN, imemREN, imemaddr, instr, instr_pc, instr_valid
    );

    // Everything around it: PC register, instruction memory, decode, control.
    modport slave (
        output pc_out, ihit, imemload, redirect, redirect_pc, halt, instr_ready,
        input  pc_in, pcWEN, imemREN, imemaddr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: reads the current PC, requests the instruction, buffers it in a
// single entry toward decode and writes the next PC (sequential or redirect).
module fetch_unit #(
    parameter int WORD_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        HALTED
    } state_t;

    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);

    state_t state;

    // Fetch is active only in REQ and FULL; IDLE and HALTED never touch the PC.
    logic active;
    assign active = (state == REQ) || (state == FULL);

    // Moore read request, word-aligned address, quiet outside REQ.
    assign bus.imemREN  = (state == REQ);
    assign bus.imemaddr = (state == REQ) ? (bus.pc_out & ALIGN_MASK) : '0;

    // Next-PC write: halt suppresses it, redirect beats a same-cycle ihit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bus.pcWEN = 1'b0;
        bus.pc_in = '0;
        if (active && !bus.halt) begin
            if (bus.redirect) begin
                bus.pcWEN = 1'b1;
                bus.pc_in = bus.redirect_pc & ALIGN_MASK;
            end else if ((state == REQ) && bus.ihit) begin
                bus.pcWEN = 1'b1;
                bus.pc_in = bus.pc_out + WORD_W'(PC_STEP);
            end
        end
    end

    // Fetch FSM and instruction buffer; priority halt > redirect > ihit/ready.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            state           <= IDLE;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= bus.halt ? HALTED : REQ;
                end
                REQ, FULL: begin
                    if (bus.halt) begin
                        state           <= HALTED;
                        bus.instr_valid <= 1'b0;
                    end else if (bus.redirect) begin
                        state           <= REQ;
                        bus.instr_valid <= 1'b0;
                    end else if (state == REQ) begin
                        if (bus.ihit) begin
                            bus.instr       <= bus.imemload;
                            bus.instr_pc    <= bus.pc_out;
                            bus.instr_valid <= 1'b1;
                            state           <= FULL;
                        end
                    end else if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        state           <= REQ;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;
    localparam int W = 32;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    fetch_unit_if #(.WORD_W(W)) bus ();

    fetch_unit #(.WORD_W(W), .PC_STEP(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a queue holding at most one fetched instruction, a sticky halt
    // flag and a "first cycle after reset" flag. The PC register is modelled
    // here too, updated with whatever the model says should be written.
    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] addr;
    } entry_t;

    entry_t       buf_q[$];
    bit           fresh;
    bit           halted;
    logic [W-1:0] last_instr;
    logic [W-1:0] last_pc;
    logic [W-1:0] pc;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance model.
    task automatic step(input bit h, input bit r, input logic [W-1:0] rpc,
                        input bit ih, input bit rdy);
        logic [W-1:0] load;
        logic [W-1:0] npc;
        bit           active;
        bit           fetching;
        bit           wen;
        bit           has;
        load = $urandom;
        bus.halt        = h;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        bus.ihit        = ih;
        bus.instr_ready = rdy;
        bus.imemload    = load;
        bus.pc_out      = pc;
        @(negedge CLK);

        has      = (buf_q.size() != 0);
        active   = !fresh && !halted;
        fetching = active && !has;
        wen      = 1'b0;
        npc      = '0;
        if (active && !h) begin
            if (r) begin
                wen = 1'b1;
                npc = rpc & ~32'h3;
            end else if (fetching && ih) begin
                wen = 1'b1;
                npc = pc + 32'd4;
            end
        end

        check("instr_valid", W'(bus.instr_valid), W'(has));
        check("instr",       bus.instr,           last_instr);
        check("instr_pc",    bus.instr_pc,        last_pc);
        check("imemREN",     W'(bus.imemREN),     W'(fetching));
        check("imemaddr",    bus.imemaddr,        fetching ? (pc & ~32'h3) : '0);
        check("pcWEN",       W'(bus.pcWEN),       W'(wen));
        check("pc_in",       bus.pc_in,           npc);

        if (fresh) begin
            fresh = 1'b0;
            if (h) halted = 1'b1;
        end else if (!halted) begin
            if (h) begin
                halted = 1'b1;
                buf_q.delete();
            end else if (r) begin
                buf_q.delete();
            end else if (fetching && ih) begin
                buf_q.push_back('{word: load, addr: pc});
                last_instr = load;
                last_pc    = pc;
            end else if (has && rdy) begin
                buf_q.delete();
            end
        end
        if (wen) pc = npc;
        @(posedge CLK);
        #1;
    endtask

    // Reset pulse with a pending ihit/redirect: everything must read idle while held.
    task automatic do_reset();
        bus.ihit        = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.halt        = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_instr_valid", W'(bus.instr_valid), '0);
        check("rst_instr",       bus.instr,           '0);
        check("rst_instr_pc",    bus.instr_pc,        '0);
        check("rst_imemREN",     W'(bus.imemREN),     '0);
        check("rst_imemaddr",    bus.imemaddr,        '0);
        check("rst_pcWEN",       W'(bus.pcWEN),       '0);
        check("rst_pc_in",       bus.pc_in,           '0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST       = 1'b1;
        fresh      = 1'b1;
        halted     = 1'b0;
        buf_q.delete();
        last_instr = '0;
        last_pc    = '0;
        pc         = '0;
    endtask

    initial begin
        bus.pc_out      = '0;
        bus.ihit        = 1'b0;
        bus.imemload    = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.instr_ready = 1'b0;
        pc              = '0;
        @(posedge CLK);
        #1;

        // Reset, then ihit on the second cycle after release.
        do_reset();
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 0);
        // Buffer held while decode stalls, then consumed.
        repeat (4) step(0, 0, '0, 1'($urandom), 0);
        step(0, 0, '0, 0, 1);
        // Memory wait states in REQ, then fetch and consume.
        repeat (3) step(0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);
        // Redirect beats ihit in the same cycle; target is word-aligned.
        step(0, 1, 32'h0000_0103, 1, 0);
        // PC wrap-around on sequential increment.
        pc = 32'hFFFF_FFFC;
        step(0, 0, '0, 1, 0);
        // Halt beats redirect in FULL; stays halted after halt drops.
        step(1, 1, 32'h0000_0200, 0, 1);
        repeat (3) step(0, 1'($urandom), $urandom, 1, 1);
        do_reset();
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 1);

        // Random traffic, with periodic resets landing mid-operation.
        repeat (25) begin
            do_reset();
            repeat (40) begin
                if ($urandom_range(0, 15) == 0) pc = $urandom;
                if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
                step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
